// File: rtl/alu_cdb_unit.sv
// RV32I integer/control execution unit sitting behind the reservation station.
// Computes one result per cycle and drives it onto the ALU common data bus one cycle later.
module alu_cdb_unit #(
    parameter int OP_W  = 6,
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_rdy,
    input  logic             in_rollback,
    input  logic             in_rs_enable,
    input  logic [OP_W-1:0]  in_rs_type,
    input  logic [XLEN-1:0]  in_rs_pc,
    input  logic [XLEN-1:0]  in_rs_imm,
    input  logic [XLEN-1:0]  in_rs_left_oprand,
    input  logic [XLEN-1:0]  in_rs_right_oprand,
    input  logic [ROB_W-1:0] in_rs_dest,
    output logic             out_broadcast_enable,
    output logic [ROB_W-1:0] out_broadcast_reorder,
    output logic [XLEN-1:0]  out_broadcast_result,
    output logic             out_broadcast_jump,
    output logic [XLEN-1:0]  out_broadcast_target_pc
);

    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(18);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(19);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(21);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(23);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(27);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(28);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(29);

    logic             enable_q;
    logic [ROB_W-1:0] reorder_q;
    logic [XLEN-1:0]  result_q;
    logic             jump_q;
    logic [XLEN-1:0]  target_q;

    logic [XLEN-1:0]  result_d;
    logic             jump_d;
    logic [XLEN-1:0]  target_d;
    logic             accept_d;

    logic [XLEN-1:0]  opA;
    logic [XLEN-1:0]  opB;
    logic [4:0]       shamt;
    logic [XLEN-1:0]  pcPlus4;
    logic [XLEN-1:0]  pcImm;
    logic             ltSigned;
    logic             ltUnsigned;
    logic             isEqual;
    logic             taken;

    // Immediate-form ALU ops (ADDI..SRAI) take imm as the second operand.
    always_comb begin
        opA        = in_rs_left_oprand;
        opB        = (in_rs_type >= OP_ADDI && in_rs_type <= OP_SRAI) ? in_rs_imm : in_rs_right_oprand;
        shamt      = opB[4:0];
        pcPlus4    = in_rs_pc + XLEN'(4);
        pcImm      = in_rs_pc + in_rs_imm;
        ltSigned   = $signed(opA) < $signed(opB);
        ltUnsigned = opA < opB;
        isEqual    = opA == opB;
    end

    always_comb begin
        result_d = '0;
        jump_d   = 1'b0;
        target_d = pcPlus4;
        taken    = 1'b0;
        case (in_rs_type)
            OP_LUI:   result_d = in_rs_imm;
            OP_AUIPC: result_d = pcImm;
            OP_JAL: begin
                result_d = pcPlus4;
                jump_d   = 1'b1;
                target_d = pcImm;
            end
            OP_JALR: begin
                result_d = pcPlus4;
                jump_d   = 1'b1;
                target_d = (in_rs_left_oprand + in_rs_imm) & ~XLEN'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (in_rs_type)
                    OP_BEQ:  taken = isEqual;
                    OP_BNE:  taken = !isEqual;
                    OP_BLT:  taken = ltSigned;
                    OP_BGE:  taken = !ltSigned;
                    OP_BLTU: taken = ltUnsigned;
                    default: taken = !ltUnsigned;
                endcase
                jump_d   = taken;
                target_d = taken ? pcImm : pcPlus4;
            end
            OP_ADD, OP_ADDI:   result_d = opA + opB;
            OP_SUB:            result_d = opA - opB;
            OP_SLL, OP_SLLI:   result_d = opA << shamt;
            OP_SLT, OP_SLTI:   result_d = XLEN'(ltSigned);
            OP_SLTU, OP_SLTIU: result_d = XLEN'(ltUnsigned);
            OP_XOR, OP_XORI:   result_d = opA ^ opB;
            OP_SRL, OP_SRLI:   result_d = opA >> shamt;
            OP_SRA, OP_SRAI:   result_d = XLEN'($signed(opA) >>> shamt);
            OP_OR, OP_ORI:     result_d = opA | opB;
            OP_AND, OP_ANDI:   result_d = opA & opB;
            default: ;
        endcase
        accept_d = in_rs_enable && (in_rs_dest != '0);
    end

    // Rollback beats stall beats issue; a stall freezes the bus so a pending broadcast stays visible.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            enable_q  <= 1'b0;
            reorder_q <= '0;
            result_q  <= '0;
            jump_q    <= 1'b0;
            target_q  <= '0;
        end else if (in_rollback) begin
            enable_q <= 1'b0;
        end else if (in_rdy) begin
            if (accept_d) begin
                enable_q  <= 1'b1;
                reorder_q <= in_rs_dest;
                result_q  <= result_d;
                jump_q    <= jump_d;
                target_q  <= target_d;
            end else begin
                enable_q <= 1'b0;
            end
        end
    end

    assign out_broadcast_enable    = enable_q;
    assign out_broadcast_reorder   = reorder_q;
    assign out_broadcast_result    = result_q;
    assign out_broadcast_jump      = jump_q;
    assign out_broadcast_target_pc = target_q;

endmodule

// File: tb/tb_alu_cdb_unit.sv
// Scoreboard bench for alu_cdb_unit: each accepted issue queues its expected broadcast,
// and a negedge monitor checks the bus against the queue, the stall-hold value, or idle.
module tb_alu_cdb_unit;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] res;
        logic        jump;
        logic [31:0] tgt;
    } expT;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_rdy;
    logic        in_rollback;
    logic        in_rs_enable;
    logic [5:0]  in_rs_type;
    logic [31:0] in_rs_pc;
    logic [31:0] in_rs_imm;
    logic [31:0] in_rs_left_oprand;
    logic [31:0] in_rs_right_oprand;
    logic [3:0]  in_rs_dest;
    logic        out_broadcast_enable;
    logic [3:0]  out_broadcast_reorder;
    logic [31:0] out_broadcast_result;
    logic        out_broadcast_jump;
    logic [31:0] out_broadcast_target_pc;

    int vectors = 0;
    int miscompares = 0;

    expT sb[$];
    expT pendExp;
    expT heldExp;
    logic heldEn = 1'b0;
    logic lastRst = 1'b0;
    logic lastRdy = 1'b0;
    logic lastRb = 1'b0;

    alu_cdb_unit #(.OP_W(6), .ROB_W(4), .XLEN(32)) dut (
        .in_clk                  (in_clk),
        .in_rst                  (in_rst),
        .in_rdy                  (in_rdy),
        .in_rollback             (in_rollback),
        .in_rs_enable            (in_rs_enable),
        .in_rs_type              (in_rs_type),
        .in_rs_pc                (in_rs_pc),
        .in_rs_imm               (in_rs_imm),
        .in_rs_left_oprand       (in_rs_left_oprand),
        .in_rs_right_oprand      (in_rs_right_oprand),
        .in_rs_dest              (in_rs_dest),
        .out_broadcast_enable    (out_broadcast_enable),
        .out_broadcast_reorder   (out_broadcast_reorder),
        .out_broadcast_result    (out_broadcast_result),
        .out_broadcast_jump      (out_broadcast_jump),
        .out_broadcast_target_pc (out_broadcast_target_pc)
    );

    always #5 in_clk = ~in_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the expectation only when the bench's own view of the edge says the issue is taken.
    always @(posedge in_clk) begin
        lastRst <= in_rst;
        lastRdy <= in_rdy;
        lastRb  <= in_rollback;
        if (in_rst && !in_rollback && in_rdy && in_rs_enable && in_rs_dest != 4'd0)
            sb.push_back(pendExp);
    end

    always @(negedge in_clk) begin
        if (in_rst && lastRst) begin
            if (lastRb) begin
                checkOutput("rollbackEn", 32'(out_broadcast_enable), 32'd0);
                heldEn <= 1'b0;
            end else if (!lastRdy) begin
                checkOutput("stallEn", 32'(out_broadcast_enable), 32'(heldEn));
                if (heldEn) begin
                    checkOutput("stallTag", 32'(out_broadcast_reorder), 32'(heldExp.tag));
                    checkOutput("stallRes", out_broadcast_result, heldExp.res);
                end
            end else if (sb.size() > 0) begin
                checkOutput("en", 32'(out_broadcast_enable), 32'd1);
                checkOutput("tag", 32'(out_broadcast_reorder), 32'(sb[0].tag));
                checkOutput("result", out_broadcast_result, sb[0].res);
                checkOutput("jump", 32'(out_broadcast_jump), 32'(sb[0].jump));
                checkOutput("target", out_broadcast_target_pc, sb[0].tgt);
                heldExp <= sb[0];
                heldEn  <= 1'b1;
                void'(sb.pop_front());
            end else begin
                checkOutput("idleEn", 32'(out_broadcast_enable), 32'd0);
                heldEn <= 1'b0;
            end
        end else begin
            heldEn <= 1'b0;
        end
    end

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] a, input logic [31:0] b, input logic [3:0] dest,
                                 input logic rdy, input logic rb,
                                 input logic [31:0] expRes, input logic expJump, input logic [31:0] expTgt);
        in_rs_enable       = 1'b1;
        in_rs_type         = op;
        in_rs_pc           = pc;
        in_rs_imm          = imm;
        in_rs_left_oprand  = a;
        in_rs_right_oprand = b;
        in_rs_dest         = dest;
        in_rdy             = rdy;
        in_rollback        = rb;
        pendExp.tag        = dest;
        pendExp.res        = expRes;
        pendExp.jump       = expJump;
        pendExp.tgt        = expTgt;
        @(posedge in_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_rs_enable = 1'b0;
            in_rdy       = 1'b1;
            in_rollback  = 1'b0;
            @(posedge in_clk);
            #1;
        end
    endtask

    initial begin
        in_rst             = 1'b0;
        in_rdy             = 1'b1;
        in_rollback        = 1'b0;
        in_rs_enable       = 1'b0;
        in_rs_type         = '0;
        in_rs_pc           = '0;
        in_rs_imm          = '0;
        in_rs_left_oprand  = '0;
        in_rs_right_oprand = '0;
        in_rs_dest         = '0;
        pendExp            = '{tag: 4'd0, res: 32'd0, jump: 1'b0, tgt: 32'd0};
        #3;
        checkOutput("rstEn", 32'(out_broadcast_enable), 32'd0);
        checkOutput("rstTag", 32'(out_broadcast_reorder), 32'd0);
        checkOutput("rstRes", out_broadcast_result, 32'd0);
        checkOutput("rstJump", 32'(out_broadcast_jump), 32'd0);
        checkOutput("rstTgt", out_broadcast_target_pc, 32'd0);
        @(posedge in_clk);
        @(posedge in_clk);
        #1;
        in_rst = 1'b1;
        idle(1);

        // ALU ops, then an idle cycle
        applyStimulus(6'd11, 32'h40, 32'h0, 32'd5, 32'd7, 4'd3, 1'b1, 1'b0, 32'd12, 1'b0, 32'h44);
        idle(1);
        applyStimulus(6'd12, 32'h40, 32'h0, 32'd0, 32'd1, 4'd4, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h44);
        applyStimulus(6'd18, 32'h40, 32'h0, 32'h8000_0000, 32'h21, 4'd5, 1'b1, 1'b0, 32'hC000_0000, 1'b0, 32'h44);
        applyStimulus(6'd15, 32'h40, 32'h0, 32'hFFFF_FFFF, 32'd1, 4'd6, 1'b1, 1'b0, 32'd0, 1'b0, 32'h44);
        applyStimulus(6'd14, 32'h40, 32'h0, 32'hFFFF_FFFF, 32'd1, 4'd7, 1'b1, 1'b0, 32'd1, 1'b0, 32'h44);
        applyStimulus(6'd1, 32'h40, 32'h1234_5000, 32'd9, 32'd9, 4'd8, 1'b1, 1'b0, 32'h1234_5000, 1'b0, 32'h44);
        applyStimulus(6'd2, 32'h1000, 32'h2000, 32'd0, 32'd0, 4'd9, 1'b1, 1'b0, 32'h3000, 1'b0, 32'h1004);
        idle(1);

        // Control transfers
        applyStimulus(6'd7, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd2, 4'd1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h120);
        applyStimulus(6'd10, 32'h100, 32'h20, 32'd1, 32'd2, 4'd2, 1'b1, 1'b0, 32'd0, 1'b0, 32'h104);
        applyStimulus(6'd4, 32'h100, 32'h0, 32'h203, 32'd0, 4'd3, 1'b1, 1'b0, 32'h104, 1'b1, 32'h202);
        applyStimulus(6'd3, 32'h100, 32'h20, 32'd0, 32'd0, 4'd4, 1'b1, 1'b0, 32'h104, 1'b1, 32'h120);
        applyStimulus(6'd6, 32'h100, 32'h20, 32'd3, 32'd3, 4'd5, 1'b1, 1'b0, 32'd0, 1'b0, 32'h104);
        applyStimulus(6'd8, 32'h100, 32'h20, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 4'd6, 1'b1, 1'b0, 32'd0, 1'b1, 32'h120);
        applyStimulus(6'd30, 32'h100, 32'h20, 32'd3, 32'd4, 4'd7, 1'b1, 1'b0, 32'd0, 1'b0, 32'h104);
        idle(1);

        // Back-to-back tags 1..4
        applyStimulus(6'd21, 32'h200, 32'hFFFF_FFFD, 32'd10, 32'd99, 4'd1, 1'b1, 1'b0, 32'd7, 1'b0, 32'h204);
        applyStimulus(6'd16, 32'h200, 32'h0, 32'h0000_F0F0, 32'h0000_0FF0, 4'd2, 1'b1, 1'b0, 32'h0000_FF00, 1'b0, 32'h204);
        applyStimulus(6'd27, 32'h200, 32'h25, 32'd1, 32'd0, 4'd3, 1'b1, 1'b0, 32'h20, 1'b0, 32'h204);
        applyStimulus(6'd17, 32'h200, 32'h0, 32'h8000_0000, 32'd31, 4'd4, 1'b1, 1'b0, 32'd1, 1'b0, 32'h204);
        idle(2);

        // Stall holds the broadcast; issue during stall is ignored
        applyStimulus(6'd21, 32'h300, 32'd1, 32'd100, 32'd0, 4'd5, 1'b1, 1'b0, 32'd101, 1'b0, 32'h304);
        for (int i = 0; i < 3; i++)
            applyStimulus(6'd11, 32'h300, 32'd0, 32'd1, 32'd1, 4'd8, 1'b0, 1'b0, 32'd2, 1'b0, 32'h304);
        idle(2);

        // Rollback beats stall and issue; dest 0 is dropped
        applyStimulus(6'd11, 32'h400, 32'd0, 32'd1, 32'd1, 4'd9, 1'b1, 1'b0, 32'd2, 1'b0, 32'h404);
        applyStimulus(6'd11, 32'h400, 32'd0, 32'd2, 32'd2, 4'd6, 1'b0, 1'b1, 32'd4, 1'b0, 32'h404);
        applyStimulus(6'd11, 32'h400, 32'd0, 32'd3, 32'd3, 4'd10, 1'b1, 1'b1, 32'd6, 1'b0, 32'h404);
        applyStimulus(6'd11, 32'h400, 32'd0, 32'd4, 32'd4, 4'd0, 1'b1, 1'b0, 32'd8, 1'b0, 32'h404);
        idle(1);

        // Asynchronous reset kills a visible broadcast
        applyStimulus(6'd11, 32'h500, 32'd0, 32'd2, 32'd3, 4'd7, 1'b1, 1'b0, 32'd5, 1'b0, 32'h504);
        in_rs_enable = 1'b0;
        @(negedge in_clk);
        #2;
        in_rst = 1'b0;
        #1;
        checkOutput("rstAsyncEn", 32'(out_broadcast_enable), 32'd0);
        @(posedge in_clk);
        #1;
        in_rst = 1'b1;
        idle(2);

        checkOutput("sbDrain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cdb_unit.md
Name: alu_cdb_unit

Overview:
- Execution end of the reservation-station issue interface.
- Accepts one ready arithmetic, jump or branch operation per cycle from the reservation station and computes the RV32I result.
- Broadcasts result, reorder tag and branch/jump resolution on the ALU common data bus to RS, LSB and ROB.
- Fixed one-cycle issue-to-broadcast latency; flushed by ROB rollback.

Parameters:
- OP_W, 6: operator code width.
- ROB_W, 4: reorder tag width. Tag 0 means "no entry".
- XLEN, 32: data and address width.

Ports:
- in_clk  input  1  clock.
- in_rst  input  1  reset, asynchronous, active-low.
- in_rdy  input  1  global ready. Low means stall.
- in_rollback  input  1  ROB flush request.
- in_rs_enable  input  1  issue valid.
- in_rs_type  input  OP_W  operator code.
- in_rs_pc  input  XLEN  instruction PC.
- in_rs_imm  input  XLEN  sign-extended immediate.
- in_rs_left_oprand  input  XLEN  rs1 value (Vj).
- in_rs_right_oprand  input  XLEN  rs2 value (Vk).
- in_rs_dest  input  ROB_W  destination reorder tag.
- out_broadcast_enable  output  1  CDB valid.
- out_broadcast_reorder  output  ROB_W  tag.
- out_broadcast_result  output  XLEN  value written to rd.
- out_broadcast_jump  output  1  control transfer taken.
- out_broadcast_target_pc  output  XLEN  next PC for control ops.

Behaviour:
- Reset (in_rst==0, asynchronous): all outputs 0. Release is sampled on in_clk.
- Operator codes:
  - 1 LUI, 2 AUIPC, 3 JAL, 4 JALR.
  - 5 BEQ, 6 BNE, 7 BLT, 8 BGE, 9 BLTU, 10 BGEU.
  - 11 ADD, 12 SUB, 13 SLL, 14 SLT, 15 SLTU, 16 XOR, 17 SRL, 18 SRA, 19 OR, 20 AND.
  - 21 ADDI, 22 SLTI, 23 SLTIU, 24 XORI, 25 ORI, 26 ANDI, 27 SLLI, 28 SRLI, 29 SRAI.
- Second operand: imm for codes 21-29, right operand otherwise.
- Arithmetic rules:
  - Add/sub wrap modulo 2^32.
  - Shifts use operand bits [4:0] only.
  - SRA/SRAI are arithmetic.
  - SLT* produce 0 or 1. Signed compare for SLT/SLTI/BLT/BGE; unsigned for the U forms.
- Results per op:
  - LUI: result = imm.
  - AUIPC: result = pc+imm.
  - JAL: result = pc+4, jump = 1, target = pc+imm.
  - JALR: result = pc+4, jump = 1, target = (rs1+imm) & ~1.
  - Branches: result = 0, jump = condition, target = pc+imm if taken, else pc+4.
  - Non-control ops: jump = 0, target = pc+4.
  - Undefined code (0, 30-63): broadcast still issued with result 0, jump 0, target pc+4. The ROB must never hang on a tag.
- Latency: operation accepted at edge N (in_rdy=1, in_rs_enable=1, in_rs_dest!=0) is broadcast in the cycle after edge N, valid for exactly one cycle.
- Back-to-back issues give back-to-back broadcasts. No internal queue; throughput is 1 op/cycle.
- in_rs_enable=0 at an active edge: out_broadcast_enable <= 0. Other outputs hold their last values.
- in_rs_dest==0 with enable: dropped, no broadcast (enable <= 0).
- in_rdy=0: all output registers hold, including enable, so a pending broadcast stays visible. The issue input is ignored; the RS is stalled by the same signal.
- in_rollback=1 at an edge, regardless of in_rdy: out_broadcast_enable <= 0 and the same-cycle issue is discarded. Other outputs are don't-care afterwards.
- in_rollback takes priority over in_rdy and over issue.
- Reset mid-operation: the pending broadcast is lost immediately (enable goes low asynchronously).

Test Plan:
- Reset asserted low, then released. Issue ADD tag 3, 5+7 → next cycle enable=1, reorder=3, result=12, jump=0, target=pc+4. Following idle cycle → enable=0.
- SUB 0 - 1 → result 0xFFFFFFFF. SRA 0x80000000 by 0x21 → 0xC0000000 (shift amount 1). SLTU 0xFFFFFFFF<1 → 0. SLT 0xFFFFFFFF<1 → 1.
- Branches, pc=0x100, imm=0x20:
  - BLT -1<2 → jump=1, target=0x120, result=0.
  - BGEU 1>=2 → jump=0, target=0x104.
  - JALR rs1=0x203, imm=0 → result=0x104, target=0x202.
- Back-to-back: 4 issues on consecutive cycles, tags 1..4 → 4 consecutive broadcasts in order, each for one cycle.
- Stall: issue ADDI tag 5 then in_rdy=0 for 3 cycles → broadcast (tag 5, enable 1) held steady for all 3 cycles. Issue while stalled → no effect.
- Rollback asserted in the same cycle as issue tag 6 with in_rdy=0 → no broadcast of tag 6, enable=0 next cycle. Dest 0 issue → no broadcast.
